// File: rtl/t01_keypad_scanner.sv
// t01_keypad_scanner: debounced NROWS x NCOLS keypad scanner feeding a key FIFO.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module t01_keypad_scanner #(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_RATE     = 10000,
    localparam int KW = $clog2(NROWS*NCOLS),
    localparam int CW = $clog2(FIFO_DEPTH+1)
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             enable,
    input  logic [NROWS-1:0] rows,
    output logic [NCOLS-1:0] cols,
    output logic [KW-1:0]    key_data,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [CW-1:0]    fifo_count,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic             pressed
);

    localparam int RIW = $clog2(NROWS);
    localparam int CIW = $clog2(NCOLS);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES+1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE_P,
        HELD,
        DEBOUNCE_R
    } state_t;

    state_t         state;
    logic [CIW-1:0] col_idx;
    logic [CIW-1:0] next_col;
    logic [RIW-1:0] lrow;
    logic [RIW-1:0] enc;
    logic [DW-1:0]  cnt;
    logic           any_row;
    logic           row_hit;
    logic           db_done;
    logic           push_req;
    logic           rep_push;
    logic [KW-1:0]  lidx;

    logic [KW-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic           full;
    logic           do_pop;
    logic           do_push;

    // Priority-encode rows: the lowest-indexed active row wins
    always_comb begin
        enc = '0;
        for (int i = NROWS-1; i >= 0; i--) begin
            if (rows[i]) enc = RIW'(i);
        end
    end

    assign any_row  = |rows;
    assign row_hit  = any_row && (enc == lrow);
    assign db_done  = (cnt == DW'(DEBOUNCE_CYCLES-1));
    assign next_col = (col_idx == CIW'(NCOLS-1)) ? '0 : col_idx + 1'b1;
    // Column is frozen outside SCAN, so col_idx is the latched column
    assign lidx     = KW'(lrow) * KW'(NCOLS) + KW'(col_idx);
    assign push_req = ((state == DEBOUNCE_P) && row_hit && db_done)
                    || rep_push;

    // Scan / debounce state machine with registered strobes and pressed flag
    always_ff @(posedge clk) begin
        if (!nRST) begin
            state   <= SCAN;
            col_idx <= '0;
            cols    <= {{(NCOLS-1){1'b1}}, 1'b0};
            lrow    <= '0;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            unique case (state)
                SCAN: begin
                    if (any_row) begin
                        state   <= DEBOUNCE_P;
                        lrow    <= enc;
                        cnt     <= '0;
                        pressed <= 1'b1;
                    end else if (enable) begin
                        col_idx <= next_col;
                        cols    <= ~(NCOLS'(1) << next_col);
                    end
                end
                DEBOUNCE_P: begin
                    if (!row_hit) begin
                        state   <= SCAN;
                        pressed <= 1'b0;
                    end else if (db_done) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!any_row) begin
                        state <= DEBOUNCE_R;
                        cnt   <= '0;
                    end
                end
                DEBOUNCE_R: begin
                    if (any_row) begin
                        cnt <= '0;
                    end else if (db_done) begin
                        state   <= SCAN;
                        pressed <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                       : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX+1);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_tgt;
    logic          rep_first;

    assign rep_tgt  = rep_first ? RW'(REPEAT_DELAY-1) : RW'(REPEAT_RATE-1);
    assign rep_push = (state == HELD) && any_row && (rep_cnt == rep_tgt);

    // Auto-repeat timer: first gap REPEAT_DELAY, then REPEAT_RATE, only in HELD
    always_ff @(posedge clk) begin
        if (!nRST || state != HELD) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_push) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (any_row) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    logic rep_unused;
    assign rep_push   = 1'b0;
    assign rep_unused = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign key_valid = (fifo_count != '0);
    assign do_pop    = key_valid && key_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push   = push_req && (!full || do_pop);
    assign key_data  = key_valid ? mem[rptr] : '0;

    // FIFO storage array
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= lidx;
    end

    // FIFO pointers and exact occupancy count
    always_ff @(posedge clk) begin
        if (!nRST) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            fifo_count <= fifo_count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!nRST) begin
            overflow <= 1'b0;
        end else if (push_req && full && !do_pop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_t01_keypad_scanner.sv
// tb_t01_keypad_scanner: directed stimulus with a scoreboard queue of
// expected key indices, checked by a monitor on every FIFO pop.
module tb_t01_keypad_scanner;

    logic       clk = 1'b0;
    logic       nRST;
    logic       enable;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_data;
    logic       key_valid;
    logic       key_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_overflow;
    logic       pressed;

    logic       key_down;
    logic [1:0] kcol;
    logic [3:0] kmask;
    logic [3:0] raw_rows;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int mon_exp;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_N = 3;
`else
    localparam int REP_N = 1;
`endif

    t01_keypad_scanner #(
        .NROWS(4),
        .NCOLS(4),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(8)
    ) dut (
        .clk(clk),
        .nRST(nRST),
        .enable(enable),
        .rows(rows),
        .cols(cols),
        .key_data(key_data),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .clr_overflow(clr_overflow),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    // Keypad model: a held key shorts its row mask only while its column is driven low
    assign rows = (key_down && !cols[kcol]) ? kmask : raw_rows;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_pressed(input logic v, input string name);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (pressed !== v && n < 200);
        total++;
        if (pressed !== v) begin
            bad++;
            $display("FAIL %s: timeout pressed=%b want %b", name, pressed, v);
        end
    endtask

    task automatic press(input logic [1:0] c, input logic [3:0] m,
                         input int hold, input int idx, input bit expect_push);
        if (expect_push) exp_q.push_back(idx);
        kcol = c;
        kmask = m;
        key_down = 1'b1;
        wait_pressed(1'b1, "press_detect");
        repeat (hold) @(posedge clk);
        #1;
        key_down = 1'b0;
        wait_pressed(1'b0, "press_release");
    endtask

    task automatic drain(input string name);
        int n = 0;
        key_ready = 1'b1;
        while (fifo_count != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        key_ready = 1'b0;
        chk({name, "_count"}, fifo_count, 0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: every handshake pop is compared with the scoreboard head
    always @(negedge clk) begin
        if (nRST && key_valid && key_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got key %0d want none", key_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_data !== mon_exp[3:0]) begin
                    bad++;
                    $display("FAIL pop_key: got %0d want %0d", key_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0;
        enable = 1'b0;
        key_ready = 1'b0;
        clr_overflow = 1'b0;
        key_down = 1'b0;
        kcol = 2'd0;
        kmask = 4'b0000;
        raw_rows = 4'b0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cols", cols, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_pressed", pressed, 0);
        chk("rst_key_data", key_data, 0);
        nRST = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_enable_hold", cols, 4'b1110);

        // Bounce: short press then release, no push, scanning resumes
        raw_rows = 4'b0001;
        @(posedge clk); #1;
        chk("bounce_detect", pressed, 1);
        @(posedge clk); #1;
        raw_rows = 4'b0000;
        @(posedge clk); #1;
        chk("bounce_back_scan", pressed, 0);
        chk("bounce_no_push", fifo_count, 0);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("bounce_scan_resume", cols, 4'b1101);

        // Clean press on column 2, row 2 -> index 10
        exp_q.push_back(10);
        kcol = 2'd2;
        kmask = 4'b0100;
        key_down = 1'b1;
        wait_pressed(1'b1, "clean_detect");
        chk("clean_cols_frozen", cols, 4'b1011);
        repeat (3) @(posedge clk);
        #1;
        chk("clean_valid_early", key_valid, 0);
        @(posedge clk); #1;
        chk("clean_valid_rise", key_valid, 1);
        chk("clean_count", fifo_count, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("clean_cols_held", cols, 4'b1011);
        key_down = 1'b0;
        wait_pressed(1'b0, "clean_release");
        chk("clean_one_entry", fifo_count, 1);
        drain("clean_drain");

        // Backpressure: five presses, fifth dropped
        press(2'd0, 4'b0001, 6, 0, 1'b1);
        press(2'd1, 4'b0010, 6, 5, 1'b1);
        press(2'd2, 4'b0100, 6, 10, 1'b1);
        press(2'd3, 4'b1000, 6, 15, 1'b1);
        press(2'd0, 4'b0010, 6, 4, 1'b0);
        chk("bp_count_full", fifo_count, 4);
        chk("bp_overflow_set", overflow, 1);
        drain("bp_drain");
        chk("bp_overflow_sticky", overflow, 1);
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        chk("bp_overflow_clr", overflow, 0);

        // Multi-row key plus push and pop on the same edge while full
        press(2'd3, 4'b0001, 6, 3, 1'b1);
        press(2'd0, 4'b0100, 6, 8, 1'b1);
        press(2'd2, 4'b1000, 6, 14, 1'b1);
        press(2'd1, 4'b0110, 6, 5, 1'b1);
        chk("mr_count_full", fifo_count, 4);
        exp_q.push_back(2);
        kcol = 2'd2;
        kmask = 4'b0001;
        key_down = 1'b1;
        wait_pressed(1'b1, "pp_detect");
        repeat (3) @(posedge clk);
        #1;
        key_ready = 1'b1;
        @(posedge clk); #1;
        key_ready = 1'b0;
        chk("pp_count_same", fifo_count, 4);
        chk("pp_no_overflow", overflow, 0);
        key_down = 1'b0;
        wait_pressed(1'b0, "pp_release");
        drain("pp_drain");

        // Long hold: auto-repeat only when the feature is built in
        for (int i = 0; i < REP_N; i++) exp_q.push_back(15);
        kcol = 2'd3;
        kmask = 4'b1000;
        key_down = 1'b1;
        wait_pressed(1'b1, "rep_detect");
        repeat (4) @(posedge clk);
        repeat (30) @(posedge clk);
        #1;
        key_down = 1'b0;
        wait_pressed(1'b0, "rep_release");
        chk("rep_push_count", fifo_count, REP_N);
        drain("rep_drain");
        chk("rep_overflow", overflow, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
